// File: rtl/pc_fetch_seq_if.sv
// Instruction-memory port of the fetch sequencer.
// Handshake: the fetcher raises imem_req with a stable imem_addr and holds both
// until the memory returns a single-cycle imem_ack with imem_rdata valid in that
// same cycle; imem_req drops on the edge that samples imem_ack. A new request
// never starts in the cycle that follows an ack.
`timescale 1ns/1ps
interface pc_fetch_seq_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/pc_fetch_seq.sv
// Fetch sequencer: issues instruction-memory requests from the current PC,
// holds the fetched word through decode stalls and selects the next PC from
// sequential, branch, jump and exception sources.
// Optional macro PC_FETCH_ALIGN_CHECK_EN: misaligned PC targets are replaced by
// EXC_VEC and flagged on addr_err (sticky). Without it addr_err is tied low.
`timescale 1ns/1ps
module pc_fetch_seq #(
  parameter logic [31:0] RESET_VEC = 32'h0040_0000,
  parameter logic [31:0] EXC_VEC   = 32'h0040_0004,
  parameter int          MAX_WAIT  = 15,
  parameter int          WAIT_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           pc_q,
  input  logic                  stall,
  input  logic                  br_taken,
  input  logic [31:0]           br_target,
  input  logic                  jmp,
  input  logic [31:0]           jmp_target,
  input  logic                  exc,
  pc_fetch_seq_if.master        imem,
  output logic [31:0]           inst,
  output logic                  inst_valid,
  output logic                  pc_ena,
  output logic [31:0]           pc_next,
  output logic                  timeout_err,
  output logic                  addr_err,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3} state_t;

  // Redirect priority levels; a larger value wins. PRI_NONE means no redirect.
  localparam logic [1:0] PRI_NONE = 2'd0;
  localparam logic [1:0] PRI_BR   = 2'd1;
  localparam logic [1:0] PRI_JMP  = 2'd2;
  localparam logic [1:0] PRI_EXC  = 2'd3;

  state_t              state_q, state_d;
  logic                req_q, req_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         inst_q, inst_d;
  logic                iv_q, iv_d;
  logic [31:0]         pc_next_q, pc_next_d;
  logic                tmo_q, tmo_d;
  logic [1:0]          pend_pri_q, pend_pri_d;
  logic [31:0]         pend_addr_q, pend_addr_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;

  logic [1:0]          in_pri;
  logic [31:0]         in_addr;
  logic [31:0]         sel_raw;
  logic [31:0]         sel_addr;
  logic                pc_ena_c;

  // Decode this cycle's redirect requests by priority exc > jmp > br.
  always_comb begin
    in_pri  = PRI_NONE;
    in_addr = 32'h0;
    if (exc) begin
      in_pri  = PRI_EXC;
      in_addr = EXC_VEC;
    end else if (jmp) begin
      in_pri  = PRI_JMP;
      in_addr = jmp_target;
    end else if (br_taken) begin
      in_pri  = PRI_BR;
      in_addr = br_target;
    end
  end

  // Next-PC candidate: a held redirect beats a same-cycle one, which beats pc+4.
  always_comb begin
    if (pend_pri_q != PRI_NONE) begin
      sel_raw = pend_addr_q;
    end else if (in_pri != PRI_NONE) begin
      sel_raw = in_addr;
    end else begin
      sel_raw = pc_q + 32'd4;
    end
  end

`ifdef PC_FETCH_ALIGN_CHECK_EN
  logic misalign;
  logic addr_err_q;

  assign misalign = (sel_raw[1:0] != 2'b00);
  assign sel_addr = misalign ? EXC_VEC : sel_raw;

  // Sticky flag, set only when a misaligned target would have been loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_err_q <= 1'b0;
    end else if (pc_ena_c && misalign) begin
      addr_err_q <= 1'b1;
    end
  end

  assign addr_err = addr_err_q;
`else
  assign sel_addr = sel_raw;
  assign addr_err = 1'b0;
`endif

  // Next-state and register-input logic of the fetch FSM.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    addr_d      = addr_q;
    inst_d      = inst_q;
    iv_d        = iv_q;
    pc_next_d   = pc_next_q;
    tmo_d       = tmo_q;
    pend_pri_d  = pend_pri_q;
    pend_addr_d = pend_addr_q;
    cnt_d       = cnt_q;
    pc_ena_c    = 1'b0;

    // Any redirect seen after IDLE is remembered unless a stronger one is held.
    if (state_q != S_IDLE && in_pri > pend_pri_q) begin
      pend_pri_d  = in_pri;
      pend_addr_d = in_addr;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        req_d   = 1'b1;
        addr_d  = pc_q;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem.imem_ack) begin
          req_d   = 1'b0;
          state_d = S_DONE;
          // A redirect raised during this fetch makes the word stale: drop it.
          if (pend_pri_d == PRI_NONE) begin
            inst_d = imem.imem_rdata;
            iv_d   = 1'b1;
          end else begin
            iv_d   = 1'b0;
          end
        end else if (cnt_q == WAIT_W'(MAX_WAIT - 1)) begin
          cnt_d       = cnt_q + WAIT_W'(1);
          tmo_d       = 1'b1;
          req_d       = 1'b0;
          iv_d        = 1'b0;
          pend_pri_d  = PRI_EXC;
          pend_addr_d = EXC_VEC;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + WAIT_W'(1);
        end
      end
      S_DONE: begin
        if (!stall) begin
          pc_ena_c   = 1'b1;
          pc_next_d  = sel_addr;
          iv_d       = 1'b0;
          pend_pri_d = PRI_NONE;
          state_d    = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      addr_q      <= 32'h0;
      inst_q      <= 32'h0;
      iv_q        <= 1'b0;
      pc_next_q   <= RESET_VEC;
      tmo_q       <= 1'b0;
      pend_pri_q  <= PRI_NONE;
      pend_addr_q <= 32'h0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      inst_q      <= inst_d;
      iv_q        <= iv_d;
      pc_next_q   <= pc_next_d;
      tmo_q       <= tmo_d;
      pend_pri_q  <= pend_pri_d;
      pend_addr_q <= pend_addr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign inst           = inst_q;
  assign inst_valid     = iv_q;
  assign pc_ena         = pc_ena_c;
  // pc_next shows the live selection while in DONE so the PC register loads it
  // on the same edge that pc_ena is high; otherwise the last loaded value.
  assign pc_next        = (state_q == S_DONE) ? sel_addr : pc_next_q;
  assign timeout_err    = tmo_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed bench for pc_fetch_seq: a PC register model closes the loop, memory
// responses and redirects are driven step by step, outputs checked 1-2 ns after
// the rising edge.
`timescale 1ns/1ps
module tb_pc_fetch_seq;
  localparam logic [31:0] RESET_VEC = 32'h0040_0000;
  localparam logic [31:0] EXC_VEC   = 32'h0040_0004;
  localparam logic [31:0] ST_IDLE   = 32'd0;
  localparam logic [31:0] ST_FETCH  = 32'd1;
  localparam logic [31:0] ST_WAIT   = 32'd2;
  localparam logic [31:0] ST_DONE   = 32'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_q;
  logic        stall, br_taken, jmp, exc;
  logic [31:0] br_target, jmp_target;
  logic [31:0] inst, pc_next;
  logic        inst_valid, pc_ena, timeout_err, addr_err;
  logic [1:0]  dbg_state_o;

  int errors = 0;
  int checks = 0;

  pc_fetch_seq_if imem_if ();

  pc_fetch_seq dut (
    .clk(clk), .rst(rst), .pc_q(pc_q), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .jmp_target(jmp_target), .exc(exc),
    .imem(imem_if),
    .inst(inst), .inst_valid(inst_valid), .pc_ena(pc_ena), .pc_next(pc_next),
    .timeout_err(timeout_err), .addr_err(addr_err), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // PC register driven by the sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_VEC;
    else if (pc_ena) pc_q <= pc_next;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ack_set(input logic [31:0] data);
    imem_if.imem_ack   = 1'b1;
    imem_if.imem_rdata = data;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; jmp = 1'b0; exc = 1'b0;
    br_target = 32'h0; jmp_target = 32'h0;
    imem_if.imem_ack = 1'b0; imem_if.imem_rdata = 32'h0;
    tick(); tick();

    // reset state
    chk("rst_state", 32'(dbg_state_o), ST_IDLE);
    chk("rst_req", 32'(imem_if.imem_req), 32'd0);
    chk("rst_addr", imem_if.imem_addr, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_iv", 32'(inst_valid), 32'd0);
    chk("rst_pc_ena", 32'(pc_ena), 32'd0);
    chk("rst_pc_next", pc_next, RESET_VEC);
    chk("rst_tmo", 32'(timeout_err), 32'd0);
    chk("rst_aerr", 32'(addr_err), 32'd0);

    // 1: first fetch from RESET_VEC, ack one cycle after req
    rst = 1'b0;
    tick();
    chk("t1_fetch", 32'(dbg_state_o), ST_FETCH);
    chk("t1_req_lo", 32'(imem_if.imem_req), 32'd0);
    tick();
    chk("t1_req", 32'(imem_if.imem_req), 32'd1);
    chk("t1_addr", imem_if.imem_addr, 32'h0040_0000);
    tick();
    chk("t1_iv_wait", 32'(inst_valid), 32'd0);
    ack_set(32'h1111_0001);
    tick();
    imem_if.imem_ack = 1'b0;
    settle();
    chk("t1_iv", 32'(inst_valid), 32'd1);
    chk("t1_inst", inst, 32'h1111_0001);
    chk("t1_req_drop", 32'(imem_if.imem_req), 32'd0);
    chk("t1_pc_ena", 32'(pc_ena), 32'd1);
    chk("t1_pc_next", pc_next, 32'h0040_0004);
    tick();
    chk("t1_pc_ena_pulse", 32'(pc_ena), 32'd0);
    chk("t1_iv_clr", 32'(inst_valid), 32'd0);
    tick();
    chk("t1_addr2", imem_if.imem_addr, 32'h0040_0004);

    // 2: stall held five cycles in DONE
    stall = 1'b1;
    ack_set(32'h2222_0002);
    tick();
    imem_if.imem_ack = 1'b0;
    settle();
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall_pc_ena", 32'(pc_ena), 32'd0);
      chk("t2_stall_iv", 32'(inst_valid), 32'd1);
      chk("t2_stall_inst", inst, 32'h2222_0002);
      tick();
    end
    chk("t2_stall_state", 32'(dbg_state_o), ST_DONE);
    stall = 1'b0;
    settle();
    chk("t2_release_pc_ena", 32'(pc_ena), 32'd1);
    chk("t2_release_pc_next", pc_next, 32'h0040_0008);
    tick();
    chk("t2_single_pulse", 32'(pc_ena), 32'd0);
    chk("t2_fetch", 32'(dbg_state_o), ST_FETCH);

    // 3: simultaneous exc+jmp+br, then jmp alone
    tick();
    chk("t3_addr", imem_if.imem_addr, 32'h0040_0008);
    ack_set(32'h3333_0003);
    tick();
    imem_if.imem_ack = 1'b0;
    exc = 1'b1; jmp = 1'b1; jmp_target = 32'h0040_1000; br_taken = 1'b1; br_target = 32'h0040_2000;
    settle();
    chk("t3_all_pc_next", pc_next, EXC_VEC);
    chk("t3_all_pc_ena", 32'(pc_ena), 32'd1);
    chk("t3_all_iv", 32'(inst_valid), 32'd1);
    tick();
    exc = 1'b0; jmp = 1'b0; br_taken = 1'b0;
    tick();
    chk("t3_exc_addr", imem_if.imem_addr, EXC_VEC);
    ack_set(32'h4444_0004);
    tick();
    imem_if.imem_ack = 1'b0;
    jmp = 1'b1;
    settle();
    chk("t3_jmp_pc_next", pc_next, 32'h0040_1000);
    chk("t3_jmp_inst", inst, 32'h4444_0004);
    tick();
    jmp = 1'b0;
    tick();
    chk("t3_jmp_addr", imem_if.imem_addr, 32'h0040_1000);

    // 4: branch during WAIT flushes the in-flight fetch
    br_taken = 1'b1; br_target = 32'h0040_2000;
    tick();
    br_taken = 1'b0;
    ack_set(32'h5555_0005);
    tick();
    imem_if.imem_ack = 1'b0;
    settle();
    chk("t4_flush_iv", 32'(inst_valid), 32'd0);
    chk("t4_flush_inst", inst, 32'h4444_0004);
    chk("t4_pc_next", pc_next, 32'h0040_2000);
    tick();
    tick();
    chk("t4_br_addr", imem_if.imem_addr, 32'h0040_2000);

    // 4b: br, then stronger jmp overwrites, then weaker br does not
    br_taken = 1'b1; br_target = 32'h0040_3000;
    tick();
    br_taken = 1'b0; jmp = 1'b1; jmp_target = 32'h0040_5000;
    tick();
    jmp = 1'b0; br_taken = 1'b1; br_target = 32'h0040_6000;
    tick();
    br_taken = 1'b0;
    ack_set(32'h6666_0006);
    tick();
    imem_if.imem_ack = 1'b0;
    settle();
    chk("t4b_pri_pc_next", pc_next, 32'h0040_5000);
    chk("t4b_pri_iv", 32'(inst_valid), 32'd0);
    tick();
    tick();
    chk("t4b_addr", imem_if.imem_addr, 32'h0040_5000);

    // 5: no ack for 15 WAIT cycles
    for (int i = 0; i < 14; i++) tick();
    chk("t5_still_wait", 32'(dbg_state_o), ST_WAIT);
    chk("t5_req_held", 32'(imem_if.imem_req), 32'd1);
    chk("t5_no_tmo_yet", 32'(timeout_err), 32'd0);
    tick();
    settle();
    chk("t5_tmo", 32'(timeout_err), 32'd1);
    chk("t5_req_drop", 32'(imem_if.imem_req), 32'd0);
    chk("t5_iv", 32'(inst_valid), 32'd0);
    chk("t5_pc_next", pc_next, EXC_VEC);
    tick();
    tick();
    chk("t5_exc_addr", imem_if.imem_addr, EXC_VEC);
    ack_set(32'h7777_0007);
    tick();
    imem_if.imem_ack = 1'b0;
    jmp = 1'b1; jmp_target = 32'hFFFF_FFFC;
    settle();
    chk("t5_top_pc_next", pc_next, 32'hFFFF_FFFC);
    tick();
    jmp = 1'b0;
    tick();
    chk("t5_top_addr", imem_if.imem_addr, 32'hFFFF_FFFC);
    ack_set(32'h8888_0008);
    tick();
    imem_if.imem_ack = 1'b0;
    settle();
    chk("t5_wrap_pc_next", pc_next, 32'h0);
    chk("t5_tmo_sticky", 32'(timeout_err), 32'd1);
    chk("t5_wrap_inst", inst, 32'h8888_0008);
    tick();
    tick();
    chk("t5_wrap_addr", imem_if.imem_addr, 32'h0);

    // 6: reset pulse mid-WAIT, late ack ignored
    rst = 1'b1;
    settle();
    chk("t6_req_drop", 32'(imem_if.imem_req), 32'd0);
    chk("t6_state", 32'(dbg_state_o), ST_IDLE);
    chk("t6_tmo_clr", 32'(timeout_err), 32'd0);
    chk("t6_pc_next", pc_next, RESET_VEC);
    rst = 1'b0;
    ack_set(32'hDEAD_BEEF);
    tick();
    imem_if.imem_ack = 1'b0;
    chk("t6_late_state", 32'(dbg_state_o), ST_FETCH);
    chk("t6_late_inst", inst, 32'h0);
    chk("t6_late_iv", 32'(inst_valid), 32'd0);
    tick();
    chk("t6_restart_addr", imem_if.imem_addr, RESET_VEC);
    ack_set(32'h9999_0009);
    tick();
    imem_if.imem_ack = 1'b0;
    settle();
    chk("t6_inst", inst, 32'h9999_0009);
    chk("t6_iv", 32'(inst_valid), 32'd1);

    // misaligned jump target
    jmp = 1'b1; jmp_target = 32'h0040_1002;
    settle();
`ifdef PC_FETCH_ALIGN_CHECK_EN
    chk("t6_align_pc_next", pc_next, EXC_VEC);
    tick();
    jmp = 1'b0;
    chk("t6_align_err", 32'(addr_err), 32'd1);
`else
    chk("t6_noalign_pc_next", pc_next, 32'h0040_1002);
    tick();
    jmp = 1'b0;
    chk("t6_noalign_err", 32'(addr_err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
